// File: rtl/decode_in_txn_capture.sv
// decode_in_txn_capture: timestamped, opcode-filtered capture FIFO for the LC3 decode input bus
module decode_in_txn_capture #(
  parameter int INSTR_W    = 16,
  parameter int NPC_W      = 16,
  parameter int PSR_W      = 3,
  parameter int DEPTH      = 8,
  parameter int STAMP_W    = 16,
  parameter int QUALIFY    = 1,
  parameter int OVF_POLICY = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [INSTR_W-1:0]         instr_dout,
  input  logic [NPC_W-1:0]           npc_in,
  input  logic [PSR_W-1:0]           psr,
  input  logic                       enable_decode,
  input  logic                       capture_en,
  input  logic [15:0]                opcode_mask,
  input  logic                       clear_ovf,
  output logic                       txn_valid,
  input  logic                       txn_ready,
  output logic [INSTR_W-1:0]         txn_instr,
  output logic [NPC_W-1:0]           txn_npc,
  output logic [PSR_W-1:0]           txn_psr,
  output logic [STAMP_W-1:0]         txn_stamp,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt,
  output logic [1:0]                 state
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = INSTR_W + NPC_W + PSR_W + STAMP_W;
  typedef enum logic [1:0] {DISABLED = 2'd0, CAPTURING = 2'd1, DRAINING = 2'd2} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic [STAMP_W-1:0] stamp_q, stamp_d;
  logic ovf_q, ovf_d;
  logic [7:0] drop_q, drop_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic [3:0] opcode;
  logic push, pop, full, ovf_evt, accept, rd_adv;
  assign opcode  = instr_dout[INSTR_W-1 -: 4];
  assign full    = count_q == CW'(DEPTH);
  assign push    = state_q == CAPTURING && (QUALIFY == 0 || enable_decode) && opcode_mask[opcode];
  assign pop     = txn_valid && txn_ready;
  // a full FIFO that gets a push without a simultaneous pop loses one entry
  assign ovf_evt = push && full && !pop;
  assign accept  = push && (!full || pop || OVF_POLICY == 1);
  assign rd_adv  = pop || (ovf_evt && OVF_POLICY == 1);
  // next-state for pointers, occupancy, timestamp, overflow bookkeeping and FSM
  always_comb begin
    wr_d    = wr_q + PW'(accept);
    rd_d    = rd_q + PW'(rd_adv);
    count_d = count_q + CW'(accept) - CW'(rd_adv);
    stamp_d = stamp_q + 1'b1;
    ovf_d   = ovf_evt ? 1'b1 : clear_ovf ? 1'b0 : ovf_q;
    drop_d  = ovf_evt ? (clear_ovf ? 8'd1 : (&drop_q ? drop_q : drop_q + 8'd1)) : clear_ovf ? 8'd0 : drop_q;
    state_d = state_q;
    case (state_q)
      DISABLED:  state_d = capture_en ? CAPTURING : DISABLED;
      CAPTURING: state_d = capture_en ? CAPTURING : (|count_q ? DRAINING : DISABLED);
      DRAINING:  state_d = capture_en ? CAPTURING : (|count_q ? DRAINING : DISABLED);
      default:   state_d = DISABLED;
    endcase
  end
  // control registers, cleared asynchronously so a reset discards queued entries at once
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= DISABLED;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      stamp_q <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      stamp_q <= stamp_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end
  // entry storage; contents are only observable through a nonzero count
  always_ff @(posedge clock) begin
    if (accept) mem_q[wr_q] <= {instr_dout, npc_in, psr, stamp_q};
  end
  assign txn_valid  = |count_q;
  assign {txn_instr, txn_npc, txn_psr, txn_stamp} = txn_valid ? mem_q[rd_q] : '0;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;
  assign drop_cnt   = drop_q;
  assign state      = state_q;
endmodule

// File: tb/tb_decode_in_txn_capture.sv
// tb_decode_in_txn_capture: vector table, directed corner sequences and a queue-based random model
module tb_decode_in_txn_capture;
  logic clock = 1'b0, reset = 1'b0;
  logic [15:0] instr_dout = '0, npc_in = '0, opcode_mask = '0;
  logic [2:0] psr = '0;
  logic enable_decode = 1'b0, capture_en = 1'b0, clear_ovf = 1'b0, txn_ready = 1'b0;
  logic [1:0] tv, ov;
  logic [1:0][15:0] ti, tn, ts;
  logic [1:0][2:0] tp;
  logic [1:0][3:0] fc;
  logic [1:0][7:0] dc;
  logic [1:0][1:0] st;
  int checks = 0, errors = 0;
  always #5 clock = ~clock;

  decode_in_txn_capture u0 (
    .clock(clock), .reset(reset), .instr_dout(instr_dout), .npc_in(npc_in), .psr(psr),
    .enable_decode(enable_decode), .capture_en(capture_en), .opcode_mask(opcode_mask),
    .clear_ovf(clear_ovf), .txn_valid(tv[0]), .txn_ready(txn_ready), .txn_instr(ti[0]),
    .txn_npc(tn[0]), .txn_psr(tp[0]), .txn_stamp(ts[0]), .fifo_count(fc[0]),
    .overflow(ov[0]), .drop_cnt(dc[0]), .state(st[0]));

  decode_in_txn_capture #(.QUALIFY(0), .OVF_POLICY(1)) u1 (
    .clock(clock), .reset(reset), .instr_dout(instr_dout), .npc_in(npc_in), .psr(psr),
    .enable_decode(enable_decode), .capture_en(capture_en), .opcode_mask(opcode_mask),
    .clear_ovf(clear_ovf), .txn_valid(tv[1]), .txn_ready(txn_ready), .txn_instr(ti[1]),
    .txn_npc(tn[1]), .txn_psr(tp[1]), .txn_stamp(ts[1]), .fifo_count(fc[1]),
    .overflow(ov[1]), .drop_cnt(dc[1]), .state(st[1]));

  typedef struct packed {logic [15:0] i; logic [15:0] n; logic [2:0] p; logic [15:0] s;} ent_t;
  typedef struct {
    logic cap, en, rdy; logic [15:0] instr;
    logic v; logic [3:0] cnt; logic [15:0] ti; logic [15:0] ts; logic [1:0] st;
  } vec_t;

  ent_t mq [2][$];
  int mst [2];
  bit movf [2];
  int mdrop [2];
  logic [15:0] mstamp;
  int qual [2] = '{1, 0};
  int pol [2] = '{0, 1};

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  // transaction-level reference: one call per clock edge, using pre-edge inputs
  task automatic model_step(input int k);
    int sz = mq[k].size();
    bit push = mst[k] == 1 && (qual[k] == 0 || enable_decode) && opcode_mask[instr_dout[15:12]];
    int nst = mst[k];
    ent_t e = '{instr_dout, npc_in, psr, mstamp};
    if (mst[k] == 0) nst = capture_en ? 1 : 0;
    else nst = capture_en ? 1 : (sz != 0 ? 2 : 0);
    if (sz > 0 && txn_ready) void'(mq[k].pop_front());
    if (clear_ovf) begin movf[k] = 0; mdrop[k] = 0; end
    if (push) begin
      if (mq[k].size() < 8) mq[k].push_back(e);
      else begin
        movf[k] = 1;
        mdrop[k] = mdrop[k] == 255 ? 255 : mdrop[k] + 1;
        if (pol[k] == 1) begin void'(mq[k].pop_front()); mq[k].push_back(e); end
      end
    end
    mst[k] = nst;
  endtask

  task automatic step(input logic c, input logic e, input logic r, input logic cl,
                      input logic [15:0] i, input logic [15:0] m);
    @(negedge clock);
    capture_en = c; enable_decode = e; txn_ready = r; clear_ovf = cl;
    instr_dout = i; opcode_mask = m; npc_in = 16'($urandom); psr = 3'($urandom);
    model_step(0);
    model_step(1);
    mstamp++;
    @(posedge clock);
    #1;
  endtask

  task automatic cmp(input int k);
    ent_t h;
    string p = k ? "u1" : "u0";
    chk({p, " valid"}, 32'(tv[k]), 32'(mq[k].size() != 0));
    chk({p, " count"}, 32'(fc[k]), 32'(mq[k].size()));
    chk({p, " state"}, 32'(st[k]), 32'(mst[k]));
    chk({p, " overflow"}, 32'(ov[k]), 32'(movf[k]));
    chk({p, " drop_cnt"}, 32'(dc[k]), 32'(mdrop[k]));
    h = mq[k].size() != 0 ? mq[k][0] : '0;
    chk({p, " head"}, {ti[k], tn[k]}, {h.i, h.n});
    chk({p, " head_ps"}, {13'd0, tp[k], ts[k]}, {13'd0, h.p, h.s});
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    capture_en = 0; enable_decode = 0; txn_ready = 0; clear_ovf = 0;
    instr_dout = '0; opcode_mask = '0;
    @(posedge clock);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("reset valid", 32'(tv[k]), 0);
      chk("reset count", 32'(fc[k]), 0);
      chk("reset state", 32'(st[k]), 0);
      chk("reset ovf_drop", {ov[k], dc[k]}, 0);
      chk("reset data", {ti[k], ts[k]}, 0);
      mq[k].delete(); mst[k] = 0; movf[k] = 0; mdrop[k] = 0;
    end
    mstamp = '0;
    reset = 1'b1;
  endtask

  vec_t tbl [8];

  initial begin
    tbl[0] = '{1, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'd0, 2'd1};
    tbl[1] = '{1, 1, 0, 16'h1021, 1, 1, 16'h1021, 16'd1, 2'd1};
    tbl[2] = '{1, 1, 0, 16'h5260, 1, 2, 16'h1021, 16'd1, 2'd1};
    tbl[3] = '{1, 1, 0, 16'h0E02, 1, 3, 16'h1021, 16'd1, 2'd1};
    tbl[4] = '{0, 0, 1, 16'h0000, 1, 2, 16'h5260, 16'd2, 2'd2};
    tbl[5] = '{0, 0, 1, 16'h0000, 1, 1, 16'h0E02, 16'd3, 2'd2};
    tbl[6] = '{0, 0, 1, 16'h0000, 0, 0, 16'h0000, 16'd0, 2'd2};
    tbl[7] = '{0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'd0, 2'd0};
    repeat (2) @(posedge clock);

    // basic capture and ordered drain with consecutive stamps
    do_reset();
    foreach (tbl[r]) begin
      step(tbl[r].cap, tbl[r].en, tbl[r].rdy, 0, tbl[r].instr, 16'hFFFF);
      chk($sformatf("tbl%0d valid", r), 32'(tv[0]), 32'(tbl[r].v));
      chk($sformatf("tbl%0d count", r), 32'(fc[0]), 32'(tbl[r].cnt));
      chk($sformatf("tbl%0d instr", r), 32'(ti[0]), 32'(tbl[r].ti));
      chk($sformatf("tbl%0d stamp", r), 32'(ts[0]), 32'(tbl[r].ts));
      chk($sformatf("tbl%0d state", r), 32'(st[0]), 32'(tbl[r].st));
    end

    // qualification and opcode filter
    do_reset();
    step(1, 0, 0, 0, 16'h1021, 16'h0002);
    step(1, 0, 0, 0, 16'h1021, 16'h0002);
    chk("qual en0 count", 32'(fc[0]), 0);
    step(1, 1, 0, 0, 16'h1021, 16'h0002);
    step(1, 1, 0, 0, 16'h5260, 16'h0002);
    chk("filter count", 32'(fc[0]), 1);
    chk("filter instr", 32'(ti[0]), 32'h1021);

    // overflow under both policies, then drain and return to DISABLED
    do_reset();
    step(1, 0, 0, 0, 16'h0000, 16'h0001);
    for (int k = 0; k < 10; k++) step(1, 1, 0, 0, 16'(k), 16'h0001);
    for (int k = 0; k < 2; k++) begin
      chk("ovf count", 32'(fc[k]), 8);
      chk("ovf flag", 32'(ov[k]), 1);
      chk("ovf drop_cnt", 32'(dc[k]), 2);
    end
    for (int j = 0; j < 8; j++) begin
      chk("drop-new order", 32'(ti[0]), 32'(j));
      chk("overwrite order", 32'(ti[1]), 32'(j + 2));
      step(0, 0, 1, 0, 16'h0000, 16'h0000);
    end
    chk("drained count", 32'(fc[0]), 0);
    chk("drained state", 32'(st[0]), 2);
    step(0, 0, 0, 0, 16'h0000, 16'h0000);
    chk("idle state u0", 32'(st[0]), 0);
    chk("idle state u1", 32'(st[1]), 0);

    // full FIFO with push and pop together, then overflow racing clear_ovf
    do_reset();
    step(1, 0, 0, 0, 16'h0000, 16'h0001);
    for (int k = 0; k < 8; k++) step(1, 1, 0, 0, 16'(k), 16'h0001);
    step(1, 1, 1, 0, 16'h0008, 16'h0001);
    for (int k = 0; k < 2; k++) begin
      chk("full pushpop count", 32'(fc[k]), 8);
      chk("full pushpop ovf", 32'(ov[k]), 0);
      chk("full pushpop head", 32'(ti[k]), 1);
    end
    step(1, 1, 0, 1, 16'h0009, 16'h0001);
    for (int k = 0; k < 2; k++) chk("ovf beats clear", {ov[k], dc[k]}, {1'b1, 8'd1});
    chk("overwrite head", 32'(ti[1]), 2);
    chk("drop-new head", 32'(ti[0]), 1);
    step(1, 0, 0, 1, 16'h0000, 16'h0000);
    for (int k = 0; k < 2; k++) chk("clear_ovf", {ov[k], dc[k]}, 0);

    // asynchronous reset in the middle of a drain
    do_reset();
    step(1, 0, 0, 0, 16'h0000, 16'h0000);
    for (int k = 0; k < 4; k++) step(1, 1, 0, 0, 16'(k), 16'h0001);
    step(0, 0, 0, 0, 16'h0000, 16'h0000);
    chk("drain state", 32'(st[0]), 2);
    chk("drain count", 32'(fc[1]), 4);
    step(0, 0, 1, 0, 16'h0000, 16'h0000);
    step(0, 0, 1, 0, 16'h0000, 16'h0000);
    chk("mid drain count", 32'(fc[0]), 2);
    #2 reset = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("async rst valid", 32'(tv[k]), 0);
      chk("async rst count", 32'(fc[k]), 0);
      chk("async rst state", 32'(st[k]), 0);
    end

    // randomized traffic against the queue model
    do_reset();
    begin
      logic c = 1'b1;
      for (int n = 0; n < 800; n++) begin
        if ($urandom_range(0, 19) == 0) c = ~c;
        step(c, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4, $urandom_range(0, 29) == 0,
             16'($urandom), $urandom_range(0, 3) == 0 ? 16'hFFFF : 16'($urandom));
        cmp(0);
        cmp(1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
